// File: rtl/serial_audio_receiver_pkg.sv
// Shared constants and state encoding for the serial audio receiver front end.
package serial_audio_receiver_pkg;

  // Sample width shared with serial_to_spdif_transmitter.
  localparam int unsigned AUDIO_DATA_WIDTH = 24;
  localparam int unsigned DEFAULT_MAX_BITS = 64;
  localparam int unsigned BIT_CNT_W        = 7;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/serial_input_sync.sv
// Two-flop synchronizers for lrclk/sclk/sdin plus an sclk rising-edge detector
// running on the 256*fs master clock.
module serial_input_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_lrclk,
  input  logic i_sclk,
  input  logic i_sdin,
  output logic o_sclk_rise,
  output logic o_lrclk_s,
  output logic o_sdin_s
);

  logic r_lrclk_s1;
  logic r_lrclk_s2;
  logic r_sclk_s1;
  logic r_sclk_s2;
  logic r_sclk_s3;
  logic r_sdin_s1;
  logic r_sdin_s2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lrclk_s1 <= 1'b0;
      r_lrclk_s2 <= 1'b0;
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_s3  <= 1'b0;
      r_sdin_s1  <= 1'b0;
      r_sdin_s2  <= 1'b0;
    end else begin
      r_lrclk_s1 <= i_lrclk;
      r_lrclk_s2 <= r_lrclk_s1;
      r_sclk_s1  <= i_sclk;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_s3  <= r_sclk_s2;
      r_sdin_s1  <= i_sdin;
      r_sdin_s2  <= r_sdin_s1;
    end
  end

  // s3 is one cycle older than s2, so the pair decodes a single-cycle rise.
  assign o_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign o_lrclk_s   = r_lrclk_s2;
  assign o_sdin_s    = r_sdin_s2;

endmodule

// File: rtl/serial_audio_receiver.sv
// Deserializes left-justified or I2S audio words from oversampled pins into
// parallel samples with a valid strobe, channel tag and slot-overrun strobe.
module serial_audio_receiver
  import serial_audio_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned MAX_BITS   = DEFAULT_MAX_BITS
) (
  input  logic                  clk256,
  input  logic                  reset,
  input  logic                  lrclk,
  input  logic                  sclk,
  input  logic                  sdin,
  input  logic                  is_i2s,
  input  logic                  lrclk_polarity,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_left,
  output logic                  sample_valid,
  output logic                  frame_error
);

  rx_state_e             r_state;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_sample_data;
  logic                  r_lrclk_prev;
  logic                  r_sample_left;
  logic                  r_sample_valid;
  logic                  r_frame_error;

  logic                  w_sclk_rise;
  logic                  w_lrclk_s;
  logic                  w_sdin_s;
  logic                  w_boundary;
  logic [DATA_WIDTH-1:0] w_bit_mask;
  logic [DATA_WIDTH-1:0] w_shift_wr;
  logic [DATA_WIDTH-1:0] w_msb_word;

  serial_input_sync u_sync (
    .i_clk       (clk256),
    .i_reset     (reset),
    .i_lrclk     (lrclk),
    .i_sclk      (sclk),
    .i_sdin      (sdin),
    .o_sclk_rise (w_sclk_rise),
    .o_lrclk_s   (w_lrclk_s),
    .o_sdin_s    (w_sdin_s)
  );

  // Bits past DATA_WIDTH get an empty mask and are dropped.
  assign w_boundary = (w_lrclk_s != r_lrclk_prev);
  assign w_bit_mask = (32'(r_bit_cnt) < DATA_WIDTH)
                    ? (DATA_WIDTH'(1) << (DATA_WIDTH - 32'd1 - 32'(r_bit_cnt)))
                    : '0;
  assign w_shift_wr = w_sdin_s ? (r_shift | w_bit_mask) : r_shift;
  assign w_msb_word = {w_sdin_s, {(DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk256) begin
    if (reset) begin
      r_state        <= HUNT;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_sample_data  <= '0;
      r_lrclk_prev   <= 1'b0;
      r_sample_left  <= 1'b0;
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      if (w_sclk_rise) begin
        r_lrclk_prev <= w_lrclk_s;
        if (r_state == HUNT) begin
          if (w_boundary) begin
            r_state   <= RUN;
            r_shift   <= is_i2s ? '0 : w_msb_word;
            r_bit_cnt <= is_i2s ? '0 : BIT_CNT_W'(1);
          end
        end else if (w_boundary) begin
          // In I2S the boundary bit still belongs to the word being closed.
          r_sample_valid <= 1'b1;
          r_sample_left  <= (r_lrclk_prev == lrclk_polarity);
          r_sample_data  <= is_i2s ? w_shift_wr : r_shift;
          r_shift        <= is_i2s ? '0 : w_msb_word;
          r_bit_cnt      <= is_i2s ? '0 : BIT_CNT_W'(1);
        end else if (r_bit_cnt == BIT_CNT_W'(MAX_BITS)) begin
          r_frame_error <= 1'b1;
          r_state       <= HUNT;
          r_shift       <= '0;
          r_bit_cnt     <= '0;
        end else begin
          r_shift   <= w_shift_wr;
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

  assign sample_data  = r_sample_data;
  assign sample_left  = r_sample_left;
  assign sample_valid = r_sample_valid;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_serial_audio_receiver.sv
// Self-checking bench for serial_audio_receiver: directed frame table, overrun and
// mid-word reset sequences, and randomized framing against a slot-level model.
module tb_serial_audio_receiver;

  localparam int unsigned DW   = 24;
  localparam int unsigned MAXB = 64;

  logic          clk256 = 1'b0;
  logic          reset;
  logic          lrclk;
  logic          sclk;
  logic          sdin;
  logic          is_i2s;
  logic          lrclk_polarity;
  logic [DW-1:0] sample_data;
  logic          sample_left;
  logic          sample_valid;
  logic          frame_error;

  serial_audio_receiver dut (
    .clk256         (clk256),
    .reset          (reset),
    .lrclk          (lrclk),
    .sclk           (sclk),
    .sdin           (sdin),
    .is_i2s         (is_i2s),
    .lrclk_polarity (lrclk_polarity),
    .sample_data    (sample_data),
    .sample_left    (sample_left),
    .sample_valid   (sample_valid),
    .frame_error    (frame_error)
  );

  always #5 clk256 = ~clk256;

  int unsigned cyc = 0;
  always @(posedge clk256) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; logic left; int unsigned cyc; } obs_t;
  typedef struct { logic lr; logic d; int unsigned cyc; } rise_t;
  typedef struct { logic [DW-1:0] data; logic left; int ridx; } exp_t;
  typedef struct {
    logic i2s; logic pol; int half; int nbits; int nframes;
    logic [63:0] lw; logic [63:0] rw;
    logic [DW-1:0] exp_l; logic [DW-1:0] exp_r;
  } vec_t;

  obs_t        obs_q[$];
  int unsigned err_q[$];
  rise_t       rise_q[$];
  exp_t        exp_q[$];
  int          exp_err_q[$];
  logic        i2s_pend;
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Record every strobe as seen mid-cycle.
  always @(negedge clk256) begin
    if (!reset) begin
      if (sample_valid) begin
        obs_t o;
        o.data = sample_data; o.left = sample_left; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if (frame_error) err_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One sclk period; data and lrclk change while sclk is low.
  task automatic send_bit(input logic lr, input logic d, input int half);
    rise_t r;
    sclk = 1'b0; lrclk = lr; sdin = d;
    repeat (half) @(posedge clk256);
    #1;
    sclk = 1'b1;
    r.lr = lr; r.d = d; r.cyc = cyc;
    rise_q.push_back(r);
    repeat (half) @(posedge clk256);
    #1;
  endtask

  // Slot of nbits at level lr, bits MSB-aligned in 'bits'; I2S delays data by one sclk.
  task automatic send_slot(input logic lr, input logic [63:0] bits, input int nbits, input int half);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = bits[63];
      bits = bits << 1;
      if (is_i2s) begin
        send_bit(lr, i2s_pend, half);
        i2s_pend = b;
      end else begin
        send_bit(lr, b, half);
      end
    end
  endtask

  task automatic do_reset();
    sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk256);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk256);
    #1;
    obs_q.delete(); err_q.delete(); rise_q.delete();
    i2s_pend = 1'b0;
  endtask

  task automatic idle();
    repeat (10) @(posedge clk256);
    #1;
  endtask

  // Word between boundary rises s and e: LJ uses s..e-1, I2S uses s+1..e.
  function automatic exp_t build_word(input int s, input int e);
    exp_t x;
    int first;
    int last;
    x.data = '0;
    first = is_i2s ? s + 1 : s;
    last  = is_i2s ? e : e - 1;
    for (int j = first; j <= last; j++) begin
      if (j - first < int'(DW))
        x.data = x.data | (DW'(rise_q[j].d) << (int'(DW) - 1 - (j - first)));
    end
    x.left = (rise_q[s].lr == lrclk_polarity);
    x.ridx = e;
    return x;
  endfunction

  // Slot-level reference: boundaries are lrclk level changes between sampled rises.
  task automatic run_model();
    logic prev;
    bit   hunting;
    int   start;
    int   bits_in_slot;
    exp_q.delete(); exp_err_q.delete();
    prev = 1'b0; hunting = 1'b1; start = 0;
    for (int i = 0; i < rise_q.size(); i++) begin
      bits_in_slot = is_i2s ? (i - start) : (i - start + 1);
      if (rise_q[i].lr != prev) begin
        if (!hunting) exp_q.push_back(build_word(start, i));
        hunting = 1'b0;
        start = i;
      end else if (!hunting && bits_in_slot > int'(MAXB)) begin
        exp_err_q.push_back(i);
        hunting = 1'b1;
      end
      prev = rise_q[i].lr;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    run_model();
    check({tag, " nvalid"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s ev%0d data", tag, k), 64'(obs_q[k].data), 64'(exp_q[k].data));
      check($sformatf("%s ev%0d left", tag, k), 64'(obs_q[k].left), 64'(exp_q[k].left));
      check_rng($sformatf("%s ev%0d latency", tag, k),
                int'(obs_q[k].cyc - rise_q[exp_q[k].ridx].cyc), 3, 5);
      if (k > 0)
        check_rng($sformatf("%s ev%0d spacing", tag, k),
                  int'(obs_q[k].cyc - obs_q[k-1].cyc), 64, 1 << 30);
    end
    check({tag, " nerr"}, 64'(err_q.size()), 64'(exp_err_q.size()));
    n = (err_q.size() < exp_err_q.size()) ? err_q.size() : exp_err_q.size();
    for (int k = 0; k < n; k++)
      check_rng($sformatf("%s err%0d latency", tag, k),
                int'(err_q[k] - rise_q[exp_err_q[k]].cyc), 3, 5);
  endtask

  vec_t        vecs[4];
  int          nexp;
  int          nchk;
  bit          is_l;
  int          half;
  int          nfr;
  logic        lvl;
  logic [63:0] slot4;
  logic [63:0] tail;
  logic [DW-1:0] tail_word;

  initial begin
    reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdin = 1'b0;
    is_i2s = 1'b0; lrclk_polarity = 1'b0; i2s_pend = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 2, 32, 3, {24'hA5A5A5, 40'h0}, {24'h5A5A5A, 40'h0}, 24'hA5A5A5, 24'h5A5A5A};
    vecs[1] = '{1'b1, 1'b0, 2, 32, 3, {24'h800001, 40'h0}, {24'h3C3C3C, 40'h0}, 24'h800001, 24'h3C3C3C};
    vecs[2] = '{1'b0, 1'b1, 4, 16, 3, {16'h1234, 48'h0}, {16'hFEDC, 48'h0}, 24'h123400, 24'hFEDC00};
    vecs[3] = '{1'b1, 1'b1, 4, 16, 2, {16'hBEEF, 48'h0}, {16'h0F0F, 48'h0}, 24'hBEEF00, 24'h0F0F00};

    do_reset();
    @(negedge clk256);
    check("reset sample_data", 64'(sample_data), 64'h0);
    check("reset sample_left", 64'(sample_left), 64'h0);
    check("reset sample_valid", 64'(sample_valid), 64'h0);
    check("reset frame_error", 64'(frame_error), 64'h0);
    @(posedge clk256);
    #1;

    // Directed frame table; preamble sits at lrclk=0, so pol=0 loses the first left word.
    for (int v = 0; v < 4; v++) begin
      is_i2s = vecs[v].i2s; lrclk_polarity = vecs[v].pol;
      do_reset();
      send_slot(1'b0, 64'h0, 4, vecs[v].half);
      for (int f = 0; f < vecs[v].nframes; f++) begin
        send_slot(vecs[v].pol, vecs[v].lw, vecs[v].nbits, vecs[v].half);
        send_slot(~vecs[v].pol, vecs[v].rw, vecs[v].nbits, vecs[v].half);
      end
      send_slot(vecs[v].pol, 64'h0, 4, vecs[v].half);
      idle();
      nexp = vecs[v].pol ? 2 * vecs[v].nframes : 2 * vecs[v].nframes - 1;
      check($sformatf("vec%0d nvalid", v), 64'(obs_q.size()), 64'(nexp));
      nchk = (obs_q.size() < nexp) ? obs_q.size() : nexp;
      for (int k = 0; k < nchk; k++) begin
        is_l = vecs[v].pol ? (k % 2 == 0) : (k % 2 == 1);
        check($sformatf("vec%0d ev%0d data", v, k), 64'(obs_q[k].data),
              64'(is_l ? vecs[v].exp_l : vecs[v].exp_r));
        check($sformatf("vec%0d ev%0d left", v, k), 64'(obs_q[k].left), 64'(is_l));
      end
      check($sformatf("vec%0d nerr", v), 64'(err_q.size()), 64'h0);
      check_model($sformatf("vec%0d", v));
    end

    // Overrun: 70 sclks at one level, then recovery after two boundaries.
    is_i2s = 1'b0; lrclk_polarity = 1'b1;
    do_reset();
    send_slot(1'b0, 64'h0, 4, 2);
    send_slot(1'b1, {$urandom(), $urandom()}, 64, 2);
    send_slot(1'b1, {$urandom(), $urandom()}, 6, 2);
    send_slot(1'b0, {24'h13579B, 40'h0}, 32, 2);
    send_slot(1'b1, {24'h2468AC, 40'h0}, 32, 2);
    send_slot(1'b0, 64'h0, 4, 2);
    idle();
    check("ovr nerr", 64'(err_q.size()), 64'h1);
    if (err_q.size() > 0)
      check_rng("ovr err latency", int'(err_q[0] - rise_q[4 + 64].cyc), 3, 5);
    check("ovr nvalid", 64'(obs_q.size()), 64'h2);
    if (obs_q.size() > 1) begin
      check("ovr ev0 data", 64'(obs_q[0].data), 64'h13579B);
      check("ovr ev0 left", 64'(obs_q[0].left), 64'h0);
      check("ovr ev1 data", 64'(obs_q[1].data), 64'h2468AC);
      check("ovr ev1 left", 64'(obs_q[1].left), 64'h1);
    end
    check_model("ovr");

    // Reset after 10 bits of a word.
    is_i2s = 1'b0; lrclk_polarity = 1'b1;
    do_reset();
    slot4 = {24'h444444, 40'h0};
    send_slot(1'b0, 64'h0, 4, 2);
    send_slot(1'b1, {24'h111111, 40'h0}, 32, 2);
    send_slot(1'b0, {24'h222222, 40'h0}, 32, 2);
    send_slot(1'b1, slot4, 10, 2);
    check("rst pre data", 64'(sample_data), 64'h222222);
    sclk = 1'b0;
    repeat (2) @(posedge clk256);
    #1;
    reset = 1'b1;
    @(posedge clk256);
    #1;
    reset = 1'b0;
    @(negedge clk256);
    check("rst mid sample_data", 64'(sample_data), 64'h0);
    check("rst mid sample_left", 64'(sample_left), 64'h0);
    check("rst mid sample_valid", 64'(sample_valid), 64'h0);
    check("rst mid frame_error", 64'(frame_error), 64'h0);
    @(posedge clk256);
    #1;
    obs_q.delete(); err_q.delete(); rise_q.delete();
    tail = slot4 << 10;
    tail_word = tail[63:40];
    send_slot(1'b1, tail, 22, 2);
    send_slot(1'b0, {24'h333333, 40'h0}, 32, 2);
    send_slot(1'b1, 64'h0, 4, 2);
    idle();
    check("rst post nvalid", 64'(obs_q.size()), 64'h2);
    if (obs_q.size() > 1) begin
      check("rst post ev0 data", 64'(obs_q[0].data), 64'(tail_word));
      check("rst post ev0 left", 64'(obs_q[0].left), 64'h1);
      check_rng("rst post ev0 at 2nd boundary", int'(obs_q[0].cyc - rise_q[22].cyc), 3, 5);
      check("rst post ev1 data", 64'(obs_q[1].data), 64'h333333);
      check("rst post ev1 left", 64'(obs_q[1].left), 64'h0);
    end
    check_model("rst");

    // Randomized framing, slot lengths, rates and modes.
    for (int r = 0; r < 6; r++) begin
      is_i2s = 1'($urandom_range(0, 1));
      lrclk_polarity = 1'($urandom_range(0, 1));
      do_reset();
      half = $urandom_range(2, 4);
      lvl = 1'($urandom_range(0, 1));
      send_slot(lvl, 64'h0, 4, half);
      nfr = $urandom_range(2, 4);
      for (int f = 0; f < 2 * nfr; f++) begin
        lvl = ~lvl;
        send_slot(lvl, {$urandom(), $urandom()}, $urandom_range(16, 64), half);
      end
      send_slot(~lvl, 64'h0, 4, half);
      idle();
      check_model($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_audio_receiver.md
# serial_audio_receiver

Front-end stage feeding the S/PDIF transmitter. It oversamples the external serial audio bus (lrclk, sclk, sdin) on the 256·fs master clock and deserializes each channel word. Each completed word is presented as a parallel sample with a one-cycle valid strobe and a left/right tag. Both left-justified and I2S framing are supported.

## Interface
- DATA_WIDTH, 24: sample width; the first DATA_WIDTH bits after the MSB are captured.
- MAX_BITS, 64: longest legal channel slot in sclk periods; longer slots are errors.
- clk256  in  1  master clock, 256·fs; the only clock.
- reset  in  1  synchronous, active-high reset.
- lrclk  in  1  asynchronous word clock from the pins.
- sclk  in  1  asynchronous bit clock, 32/48/64·fs.
- sdin  in  1  asynchronous serial data, MSB first.
- is_i2s  in  1  1 = I2S (MSB one sclk after the lrclk change); 0 = left-justified.
- lrclk_polarity  in  1  lrclk level that denotes the left channel.
- sample_data  out  DATA_WIDTH  last completed word; held between strobes.
- sample_left  out  1  1 if sample_data is the left channel.
- sample_valid  out  1  single-cycle strobe when sample_data/sample_left update.
- frame_error  out  1  single-cycle strobe on slot overrun.

## Operation
- **Input synchronization**
  - Each of lrclk, sclk and sdin passes through two flops (s1, s2); sclk has a third flop (s3).
  - sclk_rise = s2 & ~s3.
  - On sclk_rise, the block samples lrclk_s2 and sdin_s2 and compares lrclk_s2 against lrclk_prev, the value sampled at the previous sclk_rise.
- **State machine**
  - HUNT: wait for a word boundary (lrclk_s2 != lrclk_prev at an sclk_rise). On a boundary, enter RUN and discard any partial word.
  - RUN: shift bits in. At each boundary, emit the previous word and restart.
  - In RUN, if the bit counter reaches MAX_BITS without a boundary: pulse frame_error, return to HUNT, and emit nothing.
- **Bit capture**
  - bit_cnt counts sclk_rise edges since the MSB; it is 7 bits wide and saturates at MAX_BITS.
  - A bit is written to position DATA_WIDTH-1-bit_cnt while bit_cnt < DATA_WIDTH.
  - Later bits are ignored.
  - Short words (for example 16 bits at 32·fs) leave the LSBs zero. The shift register is cleared at each word start.
- **Left-justified (is_i2s=0)**
  - The bit sampled at the boundary edge is the new word's MSB.
  - bit_cnt restarts at 0 with that bit.
- **I2S (is_i2s=1)**
  - The bit sampled at the boundary edge is the last bit of the previous word. It is written to that word if its bit_cnt < DATA_WIDTH.
  - The MSB is the next sclk_rise.
- **Channel tag:** sample_left = (lrclk_prev == lrclk_polarity) for the word being emitted, i.e. the level before the change.
- **Mode inputs:** is_i2s and lrclk_polarity are static. A change takes effect at the next boundary and may corrupt one word.
- **First word:** the first boundary after reset or HUNT only starts capture; the first sample_valid occurs at the second boundary.

## Timing
- **Reset values:** all outputs, sample_data, bit_cnt, synchronizer flops and lrclk_prev are 0; state = HUNT.
- **Pin-to-detect latency:** an sclk pin rise is seen as sclk_rise 3 clk256 cycles later (±1 for metastability).
- **Emission latency:** sample_valid, the new sample_data and the new sample_left are registered. All three change in the cycle after the boundary sclk_rise.
- frame_error is registered the same way: one cycle after the offending sclk_rise.
- **Input constraint:** sclk ≤ 64·fs, so each sclk high/low phase lasts ≥ 2 clk256 cycles. sdin and lrclk must be stable across the sampling rising edge, ±1 clk256.
- **Reset mid-word:** the next cycle is in HUNT with no strobes; the partial word is lost.
- **Strobe spacing:** sample_valid never asserts on two consecutive cycles; the minimum spacing is 16·4 clk256 cycles.

## Structure
- **Shared package/include:**
  - State encodings: HUNT=1'b0, RUN=1'b1.
  - MAX_BITS default.
  - The DATA_WIDTH=24 constant shared with serial_to_spdif_transmitter.
- **Sub-module:** serial_input_sync, a 2-flop synchronizer for 3 signals plus the sclk edge detector. Its outputs are sclk_rise, lrclk_s and sdin_s. The state machine and shifter stay in serial_audio_receiver.

## Test plan
- **Left-justified, 64·fs, lrclk_polarity=1:** left word 0xA5A5A5 and right word 0x5A5A5A, 8 padding bits each. Expected:
  - No strobe at the first boundary.
  - Then sample_valid pulses alternately with sample_data=0xA5A5A5, sample_left=1, and sample_data=0x5A5A5A, sample_left=0.
- **I2S, 64·fs, lrclk_polarity=0:** left word 0x800001 with lrclk low for left. Expected: sample_data=0x800001, sample_left=1. This confirms the one-bit MSB delay and left tagging on low.
- **Left-justified, 32·fs:** 16-bit words 0x1234 and 0xFEDC. Expected: sample_data = 0x123400 and 0xFEDC00, LSBs zero-padded.
- **Overrun:** hold lrclk constant for 70 sclk periods in RUN. Expected: one frame_error pulse at the 64th sclk_rise and no sample_valid. After two further boundaries, normal output resumes.
- **Reset mid-word:** assert reset for 1 cycle after 10 bits of a word. Expected:
  - All outputs 0 the next cycle.
  - The first post-reset sample_valid occurs only at the second boundary.
- **Latency check:** measure from the boundary sclk pin edge to sample_valid. Expected: 4 clk256 cycles, ±1.
